sram_req_responder: RTL and testbench

- Responder side of the SRAM request interface: accepts read/write requests over a valid/ready handshake and registers each accepted request.
- Performs the access one cycle later on an internal behavioral array with per-lane write mask.
- Returns read data over a valid/ready response channel.
- Replaces the bare sram_sim model in energy-characterization benches that need backpressure and in-order completion.

---
 rtl/sram_req_responder.sv | 160 ++++++++++++++++
 tb/tb_sram_req_responder.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_req_responder.sv
// sram_req_responder: registered request stage in front of a behavioural SRAM with per-lane write mask; reads answer on a valid/ready response register.
// Latency: a read accepted at edge N shows rsp_valid after edge N+1; sustains one request per cycle. Backpressure: a held response stalls stage 1 and drops req_ready.
// Optional: define SRAM_RSP_WRITE_ACK_EN to make writes return an acknowledgement (rsp_is_write=1) that obeys the same backpressure.
module sram_req_responder #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 8,
    parameter int WMASK_WIDTH = 4,
    parameter int RAM_DEPTH   = 1 << ADDR_WIDTH
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [WMASK_WIDTH-1:0] req_wmask,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic [DATA_WIDTH-1:0]  req_din,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_WIDTH-1:0]  rsp_dout,
    output logic                   rsp_err,
    output logic                   rsp_is_write
);
    localparam int LANE_W = DATA_WIDTH / WMASK_WIDTH;
    localparam int IDX_W  = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

    logic                   s1_valid_q, s1_valid_d;
    logic                   s1_we_q,    s1_we_d;
    logic [WMASK_WIDTH-1:0] s1_wmask_q, s1_wmask_d;
    logic [ADDR_WIDTH-1:0]  s1_addr_q,  s1_addr_d;
    logic [DATA_WIDTH-1:0]  s1_din_q,   s1_din_d;

    logic                   rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]  rsp_dout_q,  rsp_dout_d;
    logic                   rsp_err_q,   rsp_err_d;

    logic [DATA_WIDTH-1:0]  mem_q [RAM_DEPTH];

    logic                   s1_in_range;
    logic [IDX_W-1:0]       s1_idx;
    logic                   s1_makes_rsp;
    logic                   s1_adv;
    logic                   accept;
    logic [DATA_WIDTH-1:0]  rd_word;
    logic                   mem_we;
    logic [DATA_WIDTH-1:0]  mem_wdat;
    logic                   rsp_load;

    always_comb begin
        s1_in_range = (32'(s1_addr_q) < RAM_DEPTH);
        s1_idx      = s1_addr_q[IDX_W-1:0];
`ifdef SRAM_RSP_WRITE_ACK_EN
        s1_makes_rsp = 1'b1;
`else
        s1_makes_rsp = !s1_we_q;
`endif
        // A request that answers nothing never waits on the response register.
        s1_adv    = s1_valid_q && (!s1_makes_rsp || !rsp_valid_q || rsp_ready);
        req_ready = reset_n && (!s1_valid_q || s1_adv);
        accept    = req_valid && req_ready;

        s1_valid_d = s1_valid_q;
        s1_we_d    = s1_we_q;
        s1_wmask_d = s1_wmask_q;
        s1_addr_d  = s1_addr_q;
        s1_din_d   = s1_din_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_we_d    = req_we;
            s1_wmask_d = req_wmask;
            s1_addr_d  = req_addr;
            s1_din_d   = req_din;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    // Out-of-range addresses never touch the array, so nothing aliases.
    always_comb begin
        rd_word  = s1_in_range ? mem_q[s1_idx] : '0;
        mem_we   = s1_adv && s1_we_q && s1_in_range;
        mem_wdat = rd_word;
        for (int i = 0; i < WMASK_WIDTH; i++) begin
            if (s1_wmask_q[i]) begin
                mem_wdat[i*LANE_W +: LANE_W] = s1_din_q[i*LANE_W +: LANE_W];
            end
        end
    end

    always_comb begin
        rsp_load    = s1_adv && s1_makes_rsp;
        rsp_valid_d = rsp_valid_q;
        rsp_dout_d  = rsp_dout_q;
        rsp_err_d   = rsp_err_q;
        if (rsp_load) begin
            rsp_valid_d = 1'b1;
            rsp_dout_d  = s1_we_q ? '0 : rd_word;
            rsp_err_d   = !s1_in_range;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q  <= 1'b0;
            s1_we_q     <= 1'b0;
            s1_wmask_q  <= '0;
            s1_addr_q   <= '0;
            s1_din_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dout_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_we_q     <= s1_we_d;
            s1_wmask_q  <= s1_wmask_d;
            s1_addr_q   <= s1_addr_d;
            s1_din_q    <= s1_din_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dout_q  <= rsp_dout_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Array contents deliberately survive reset.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_q[s1_idx] <= mem_wdat;
        end
    end

`ifdef SRAM_RSP_WRITE_ACK_EN
    logic rsp_is_write_q, rsp_is_write_d;

    always_comb begin
        rsp_is_write_d = rsp_is_write_q;
        if (rsp_load) begin
            rsp_is_write_d = s1_we_q;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rsp_is_write_q <= 1'b0;
        end else begin
            rsp_is_write_q <= rsp_is_write_d;
        end
    end

    assign rsp_is_write = rsp_is_write_q;
`else
    assign rsp_is_write = 1'b0;
`endif

    assign rsp_valid = rsp_valid_q;
    assign rsp_dout  = rsp_dout_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_sram_req_responder.sv
// Bench for sram_req_responder (RAM_DEPTH=200): random and directed requests, expected responses
// queued from a word-array reference model at accept time and popped by an independent response monitor.
module tb_sram_req_responder;
    localparam int DEPTH = 200;

    typedef struct packed {
        logic [31:0] dout;
        logic        err;
        logic        wr;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [3:0]  req_wmask = 4'h0;
    logic [7:0]  req_addr = 8'h0;
    logic [31:0] req_din = 32'h0;
    logic        rsp_ready = 1'b0;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_dout;
    logic        rsp_err;
    logic        rsp_is_write;

    int          n_vec = 0;
    int          n_err = 0;
    exp_t        sb[$];
    logic [31:0] ref_mem [256];
    bit          force_en = 1'b1;
    bit          force_val = 1'b1;

    sram_req_responder #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (8),
        .WMASK_WIDTH(4),
        .RAM_DEPTH  (DEPTH)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_wmask   (req_wmask),
        .req_addr    (req_addr),
        .req_din     (req_din),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_dout    (rsp_dout),
        .rsp_err     (rsp_err),
        .rsp_is_write(rsp_is_write)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour: plain word array, byte lanes, addresses >= DEPTH ignored on write and read as 0 with err.
    task automatic model_accept(input logic we, input logic [3:0] m, input logic [7:0] a, input logic [31:0] d);
        bit in_rng;
        exp_t e;
        in_rng = (int'(a) < DEPTH);
        if (!we) begin
            e.dout = in_rng ? ref_mem[a] : 32'h0;
            e.err  = !in_rng;
            e.wr   = 1'b0;
            sb.push_back(e);
        end else begin
            if (in_rng) begin
                for (int i = 0; i < 4; i++) begin
                    if (m[i]) ref_mem[a][8*i +: 8] = d[8*i +: 8];
                end
            end
`ifdef SRAM_RSP_WRITE_ACK_EN
            e.dout = 32'h0;
            e.err  = !in_rng;
            e.wr   = 1'b1;
            sb.push_back(e);
`endif
        end
    endtask

    task automatic do_req(input logic we, input logic [3:0] m, input logic [7:0] a,
                          input logic [31:0] d, input bit commit);
        bit done;
        done      = 1'b0;
        req_valid = 1'b1;
        req_we    = we;
        req_wmask = m;
        req_addr  = a;
        req_din   = d;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clock);
            if (req_ready) begin
                done = 1'b1;
                if (commit) model_accept(we, m, a, d);
            end
        end
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL req_accept_timeout: got req_ready=0 for 300 cycles, required an accept (addr 0x%02h)", a);
        end
        @(posedge clock);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 500 && !ok; c++) begin
            @(negedge clock);
            ok = (sb.size() == 0) && !rsp_valid;
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: got %0d responses outstanding, required 0", sb.size());
        end
        @(posedge clock);
        #1;
    endtask

    task automatic rand_op();
        logic [7:0] a;
        if ($urandom_range(0, 3) == 0) begin
            @(posedge clock);
            #1;
        end
        if ($urandom_range(0, 9) < 8) a = 8'($urandom_range(0, DEPTH - 1));
        else                          a = 8'($urandom_range(DEPTH, 255));
        do_req(1'($urandom_range(0, 1)), 4'($urandom), a, $urandom, 1'b1);
    endtask

    // Consumer-side ready: random unless a directed test pins it.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            rsp_ready = force_en ? force_val : ($urandom_range(0, 3) != 0);
        end
    end

    // Response monitor: pops on each handshake, and checks hold stability under backpressure.
    initial begin
        bit          hold_vld;
        logic [31:0] hold_dout;
        logic        hold_err;
        logic        hold_wr;
        exp_t        e;
        hold_vld = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                hold_vld = 1'b0;
            end else begin
                if (hold_vld) begin
                    check("hold_rsp_valid", rsp_valid, 1);
                    check("hold_rsp_dout", rsp_dout, hold_dout);
                    check("hold_rsp_err", rsp_err, hold_err);
                    check("hold_rsp_is_write", rsp_is_write, hold_wr);
                end
                if (rsp_valid && rsp_ready) begin
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_rsp: got response dout=0x%08h, required none", rsp_dout);
                    end else begin
                        e = sb.pop_front();
                        check("rsp_dout", rsp_dout, e.dout);
                        check("rsp_err", rsp_err, e.err);
                        check("rsp_is_write", rsp_is_write, e.wr);
                    end
                end
                hold_vld  = rsp_valid && !rsp_ready;
                hold_dout = rsp_dout;
                hold_err  = rsp_err;
                hold_wr   = rsp_is_write;
            end
        end
    end

    initial begin
        #1 reset_n = 1'b0;
        #2;
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_req_ready", req_ready, 0);
        check("reset_rsp_dout", rsp_dout, 0);
        check("reset_rsp_err", rsp_err, 0);
        check("reset_rsp_is_write", rsp_is_write, 0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        for (int a = 0; a < DEPTH; a++) do_req(1'b1, 4'hF, 8'(a), $urandom, 1'b1);
        drain();

        // Full write, then a lone read with an idle pipeline to pin the latency.
        do_req(1'b1, 4'hF, 8'd5, 32'hDEADBEEF, 1'b1);
        drain();
        do_req(1'b0, 4'hF, 8'd5, 32'h0, 1'b1);
        check("lat_before", rsp_valid, 0);
        @(posedge clock);
        #1;
        check("lat_after_1_edge", rsp_valid, 1);
        drain();

        do_req(1'b1, 4'b0101, 8'd5, 32'h11223344, 1'b1);
        do_req(1'b0, 4'h0, 8'd5, 32'h0, 1'b1);
        do_req(1'b1, 4'b0000, 8'd5, 32'hFFFFFFFF, 1'b1);
        do_req(1'b0, 4'h0, 8'd5, 32'h0, 1'b1);
        drain();

        do_req(1'b1, 4'hF, 8'd210, 32'hAAAAAAAA, 1'b1);
        do_req(1'b0, 4'hF, 8'd210, 32'h0, 1'b1);
        do_req(1'b0, 4'hF, 8'd82, 32'h0, 1'b1);
        do_req(1'b0, 4'hF, 8'd255, 32'h0, 1'b1);
        do_req(1'b0, 4'hF, 8'd199, 32'h0, 1'b1);
        drain();

        for (int a = 0; a < 4; a++) do_req(1'b1, 4'hF, 8'(a), 32'(a), 1'b1);
        drain();
        force_val = 1'b0;
        fork
            begin
                for (int a = 0; a < 4; a++) do_req(1'b0, 4'hF, 8'(a), 32'h0, 1'b1);
            end
            begin
                repeat (6) @(negedge clock);
                check("bp_req_ready", req_ready, 0);
                check("bp_rsp_valid", rsp_valid, 1);
                check("bp_rsp_dout", rsp_dout, 0);
                repeat (3) @(negedge clock);
                check("bp_rsp_dout_held", rsp_dout, 0);
                force_val = 1'b1;
            end
        join
        drain();

`ifdef SRAM_RSP_WRITE_ACK_EN
        force_val = 1'b0;
        fork
            begin
                do_req(1'b1, 4'hF, 8'd3, 32'h5A5A5A5A, 1'b1);
                do_req(1'b0, 4'hF, 8'd3, 32'h0, 1'b1);
            end
            begin
                repeat (5) @(negedge clock);
                check("ack_rsp_valid", rsp_valid, 1);
                check("ack_rsp_is_write", rsp_is_write, 1);
                check("ack_rsp_dout", rsp_dout, 0);
                check("ack_req_ready_stall", req_ready, 0);
                force_val = 1'b1;
            end
        join
        drain();
`endif

        force_en = 1'b0;
        for (int k = 0; k < 500; k++) rand_op();
        force_en  = 1'b1;
        force_val = 1'b1;
        drain();

        // Reset while the second write to addr 7 is still in stage 1: it must be lost.
        do_req(1'b1, 4'hF, 8'd7, 32'h1, 1'b1);
        do_req(1'b1, 4'hF, 8'd7, 32'h2, 1'b0);
        reset_n = 1'b0;
        sb.delete();
        #1;
        check("rst_mid_rsp_valid", rsp_valid, 0);
        check("rst_mid_req_ready", req_ready, 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        do_req(1'b0, 4'hF, 8'd7, 32'h0, 1'b1);
        do_req(1'b0, 4'hF, 8'd82, 32'h0, 1'b1);
        drain();

        check("final_queue_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
